// File: rtl/udp_roce_conn_meta_tx_512_if.sv
// Bus bundles for the RoCE CM metadata transmitter: command input channel and
// UDP header + 512-bit payload output channel.
interface udp_roce_conn_meta_tx_512_cmd_if;
  logic         valid;
  logic         ready;
  logic [31:0]  ip_source_ip;
  logic [31:0]  ip_dest_ip;
  logic         qp_valid;
  logic [23:0]  rem_qpn;
  logic [23:0]  loc_qpn;
  logic [23:0]  rem_psn;
  logic [23:0]  loc_psn;
  logic [31:0]  r_key;
  logic [63:0]  rem_base_addr;
  logic         tx_valid;
  logic         tx_start;
  logic         tx_write_type;
  logic [31:0]  tx_rem_ip_addr;
  logic [63:0]  tx_rem_addr_offset;
  logic [31:0]  tx_dma_length;
  logic [15:0]  tx_rem_udp_port;

  modport master (
    output valid, ip_source_ip, ip_dest_ip, qp_valid, rem_qpn, loc_qpn, rem_psn,
           loc_psn, r_key, rem_base_addr, tx_valid, tx_start, tx_write_type,
           tx_rem_ip_addr, tx_rem_addr_offset, tx_dma_length, tx_rem_udp_port,
    input  ready
  );
  modport slave (
    input  valid, ip_source_ip, ip_dest_ip, qp_valid, rem_qpn, loc_qpn, rem_psn,
           loc_psn, r_key, rem_base_addr, tx_valid, tx_start, tx_write_type,
           tx_rem_ip_addr, tx_rem_addr_offset, tx_dma_length, tx_rem_udp_port,
    output ready
  );
endinterface

interface udp_roce_conn_meta_tx_512_udp_if;
  logic         hdr_valid;
  logic         hdr_ready;
  logic [5:0]   ip_dscp;
  logic [1:0]   ip_ecn;
  logic [7:0]   ip_ttl;
  logic [31:0]  ip_source_ip;
  logic [31:0]  ip_dest_ip;
  logic [15:0]  source_port;
  logic [15:0]  dest_port;
  logic [15:0]  length;
  logic [15:0]  checksum;
  logic [511:0] tdata;
  logic [63:0]  tkeep;
  logic         tvalid;
  logic         tready;
  logic         tlast;
  logic         tuser;

  modport master (
    output hdr_valid, ip_dscp, ip_ecn, ip_ttl, ip_source_ip, ip_dest_ip,
           source_port, dest_port, length, checksum,
           tdata, tkeep, tvalid, tlast, tuser,
    input  hdr_ready, tready
  );
  modport slave (
    input  hdr_valid, ip_dscp, ip_ecn, ip_ttl, ip_source_ip, ip_dest_ip,
           source_port, dest_port, length, checksum,
           tdata, tkeep, tvalid, tlast, tuser,
    output hdr_ready, tready
  );
endinterface

// File: rtl/udp_roce_conn_meta_tx_512.sv
// Serializes one QP-info/TX-metadata command into a 44-byte UDP metadata frame.
// Optional inter-frame gap enabled by defining ROCE_CM_TX_RATE_LIMIT_EN.
module udp_roce_conn_meta_tx_512 #(
  parameter logic [15:0] SRC_UDP_PORT  = 16'h4321,
  parameter logic [15:0] DEST_UDP_PORT = 16'h4321,
  parameter logic [7:0]  IP_TTL        = 8'd64,
  parameter int unsigned MIN_GAP       = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  udp_roce_conn_meta_tx_512_cmd_if.slave        s_cmd,
  udp_roce_conn_meta_tx_512_udp_if.master       m_udp,
  output logic [31:0]                           frame_count,
  output logic                                  busy
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  state_e       state_q, state_d;
  logic         ready_q, ready_d;
  logic         hdr_vld_q, hdr_vld_d;
  logic         pay_vld_q, pay_vld_d;
  logic [31:0]  frame_cnt_q, frame_cnt_d;
  logic [31:0]  src_ip_q, dst_ip_q;
  logic [511:0] tdata_q;
  logic         accept;

  // Fields arrive as one big-endian vector (byte 0 in the MSBs); the wire
  // format wants byte k at tdata[8k+7:8k].
  function automatic logic [511:0] pack_payload(input logic [351:0] be);
    logic [511:0] p;
    p = '0;
    for (int k = 0; k < 44; k++) p[8*k +: 8] = be[8*(43-k) +: 8];
    return p;
  endfunction

  assign accept = ready_q & s_cmd.valid;

`ifdef ROCE_CM_TX_RATE_LIMIT_EN
  localparam logic [15:0] GAP_LOAD = 16'(MIN_GAP);
  logic [15:0] gap_q, gap_d;

  always_ff @(posedge clk) begin
    if (rst) gap_q <= '0;
    else     gap_q <= gap_d;
  end
`else
  logic [15:0] unused_min_gap;
  assign unused_min_gap = 16'(MIN_GAP);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      hdr_vld_q   <= 1'b0;
      pay_vld_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      hdr_vld_q   <= hdr_vld_d;
      pay_vld_q   <= pay_vld_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    hdr_vld_d   = hdr_vld_q;
    pay_vld_d   = pay_vld_q;
    frame_cnt_d = frame_cnt_q;
`ifdef ROCE_CM_TX_RATE_LIMIT_EN
    gap_d       = gap_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = SEND;
          ready_d   = 1'b0;
          hdr_vld_d = 1'b1;
          pay_vld_d = 1'b1;
        end else begin
`ifdef ROCE_CM_TX_RATE_LIMIT_EN
          if (gap_q != '0) gap_d = gap_q - 16'd1;
          ready_d = (gap_d == '0);
`else
          ready_d = 1'b1;
`endif
        end
      end
      SEND: begin
        // Each channel retires independently; the frame ends with the later one.
        hdr_vld_d = hdr_vld_q & ~m_udp.hdr_ready;
        pay_vld_d = pay_vld_q & ~m_udp.tready;
        if (!hdr_vld_d && !pay_vld_d) begin
          state_d     = IDLE;
          frame_cnt_d = frame_cnt_q + 32'd1;
`ifdef ROCE_CM_TX_RATE_LIMIT_EN
          gap_d   = GAP_LOAD;
          ready_d = (gap_d == '0);
`else
          ready_d = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      src_ip_q <= s_cmd.ip_source_ip;
      dst_ip_q <= s_cmd.ip_dest_ip;
      tdata_q  <= pack_payload({7'd0, s_cmd.qp_valid,
                                s_cmd.rem_qpn, s_cmd.loc_qpn,
                                s_cmd.rem_psn, s_cmd.loc_psn,
                                s_cmd.r_key, s_cmd.rem_base_addr,
                                5'd0, s_cmd.tx_write_type, s_cmd.tx_start, s_cmd.tx_valid,
                                s_cmd.tx_rem_ip_addr, s_cmd.tx_rem_addr_offset,
                                s_cmd.tx_dma_length, s_cmd.tx_rem_udp_port});
    end
  end

  assign s_cmd.ready        = ready_q;
  assign m_udp.hdr_valid    = hdr_vld_q;
  assign m_udp.ip_dscp      = 6'd0;
  assign m_udp.ip_ecn       = 2'd0;
  assign m_udp.ip_ttl       = IP_TTL;
  assign m_udp.ip_source_ip = src_ip_q;
  assign m_udp.ip_dest_ip   = dst_ip_q;
  assign m_udp.source_port  = SRC_UDP_PORT;
  assign m_udp.dest_port    = DEST_UDP_PORT;
  assign m_udp.length       = 16'd52;
  assign m_udp.checksum     = 16'd0;
  assign m_udp.tdata        = tdata_q;
  assign m_udp.tkeep        = 64'h0000_0FFF_FFFF_FFFF;
  assign m_udp.tvalid       = pay_vld_q;
  assign m_udp.tlast        = 1'b1;
  assign m_udp.tuser        = 1'b0;
  assign frame_count        = frame_cnt_q;
  assign busy               = (state_q == SEND);

endmodule

// File: tb/tb_udp_roce_conn_meta_tx_512.sv
// Directed bench for udp_roce_conn_meta_tx_512: reset, packing, per-channel
// stalls, back-to-back commands and reset in the middle of a frame.
module tb_udp_roce_conn_meta_tx_512;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] frame_count;
  logic        busy;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] fc_exp = 32'd0;

  localparam int GAP = 16;
`ifdef ROCE_CM_TX_RATE_LIMIT_EN
  localparam int SPACING = GAP + 2;
`else
  localparam int SPACING = 2;
`endif
  localparam logic RDY_AFTER = (SPACING == 2);

  udp_roce_conn_meta_tx_512_cmd_if cmd_bus ();
  udp_roce_conn_meta_tx_512_udp_if udp_bus ();

  udp_roce_conn_meta_tx_512 #(
    .SRC_UDP_PORT (16'hC0DE),
    .DEST_UDP_PORT(16'h4321),
    .IP_TTL       (8'd64),
    .MIN_GAP      (GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_cmd      (cmd_bus),
    .m_udp      (udp_bus),
    .frame_count(frame_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] put_be(input logic [511:0] p, input int off,
                                          input int n, input logic [63:0] v);
    logic [511:0] r;
    r = p;
    for (int i = 0; i < n; i++) r[8*(off+i) +: 8] = v[8*(n-1-i) +: 8];
    return r;
  endfunction

  function automatic logic [511:0] model_payload();
    logic [511:0] p;
    p = '0;
    p[0]   = cmd_bus.qp_valid;
    p      = put_be(p, 1, 3, 64'(cmd_bus.rem_qpn));
    p      = put_be(p, 4, 3, 64'(cmd_bus.loc_qpn));
    p      = put_be(p, 7, 3, 64'(cmd_bus.rem_psn));
    p      = put_be(p, 10, 3, 64'(cmd_bus.loc_psn));
    p      = put_be(p, 13, 4, 64'(cmd_bus.r_key));
    p      = put_be(p, 17, 8, cmd_bus.rem_base_addr);
    p[200] = cmd_bus.tx_valid;
    p[201] = cmd_bus.tx_start;
    p[202] = cmd_bus.tx_write_type;
    p      = put_be(p, 26, 4, 64'(cmd_bus.tx_rem_ip_addr));
    p      = put_be(p, 30, 8, cmd_bus.tx_rem_addr_offset);
    p      = put_be(p, 38, 4, 64'(cmd_bus.tx_dma_length));
    p      = put_be(p, 42, 2, 64'(cmd_bus.tx_rem_udp_port));
    return p;
  endfunction

  task automatic set_cmd(input int id);
    cmd_bus.ip_source_ip       = 32'h0A00_0000 + 32'(id);
    cmd_bus.ip_dest_ip         = 32'h0B00_0000 + 32'(id);
    cmd_bus.qp_valid           = id[0];
    cmd_bus.rem_qpn            = 24'h100000 + 24'(id * 3);
    cmd_bus.loc_qpn            = 24'h200000 + 24'(id * 5);
    cmd_bus.rem_psn            = 24'h300000 + 24'(id * 7);
    cmd_bus.loc_psn            = 24'h400000 + 24'(id * 11);
    cmd_bus.r_key              = 32'hA5A5_0000 + 32'(id);
    cmd_bus.rem_base_addr      = 64'h0123_4567_0000_0000 + 64'(id);
    cmd_bus.tx_valid           = id[1];
    cmd_bus.tx_start           = id[2];
    cmd_bus.tx_write_type      = id[0];
    cmd_bus.tx_rem_ip_addr     = 32'hC0A8_0100 + 32'(id);
    cmd_bus.tx_rem_addr_offset = 64'hFEDC_BA98_0000_0000 + 64'(id * 64);
    cmd_bus.tx_dma_length      = 32'h0000_0100 * 32'(id + 1);
    cmd_bus.tx_rem_udp_port    = 16'h1000 + 16'(id);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (cmd_bus.ready !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    tests++;
    if (cmd_bus.ready !== 1'b1) begin
      fails++;
      $display("FAIL wait_ready: s_cmd_ready=%b after %0d cycles, want 1", cmd_bus.ready, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    tests++; if (cmd_bus.ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", cmd_bus.ready); end
    tests++; if (udp_bus.hdr_valid !== 1'b0) begin fails++; $display("FAIL reset_hdr_valid: got %b want 0", udp_bus.hdr_valid); end
    tests++; if (udp_bus.tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid: got %b want 0", udp_bus.tvalid); end
    tests++; if (frame_count !== 32'd0) begin fails++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    step();
    tests++; if (cmd_bus.ready !== 1'b1) begin fails++; $display("FAIL reset_ready_rise: got %b want 1", cmd_bus.ready); end
  endtask

  task automatic test_single_frame();
    logic [511:0] exp;
    set_cmd(0);
    cmd_bus.ip_source_ip       = 32'hC0A8_0001;
    cmd_bus.ip_dest_ip         = 32'hC0A8_0002;
    cmd_bus.qp_valid           = 1'b1;
    cmd_bus.rem_qpn            = 24'h000011;
    cmd_bus.loc_qpn            = 24'h000012;
    cmd_bus.rem_psn            = 24'hABCDEF;
    cmd_bus.loc_psn            = 24'h123456;
    cmd_bus.r_key              = 32'hDEADBEEF;
    cmd_bus.rem_base_addr      = 64'h1122_3344_5566_7788;
    cmd_bus.tx_valid           = 1'b1;
    cmd_bus.tx_start           = 1'b1;
    cmd_bus.tx_write_type      = 1'b0;
    cmd_bus.tx_rem_ip_addr     = 32'hC0A8_0063;
    cmd_bus.tx_rem_addr_offset = 64'h0000_0000_0000_0040;
    cmd_bus.tx_dma_length      = 32'h0000_1000;
    cmd_bus.tx_rem_udp_port    = 16'h12B7;
    exp = model_payload();
    udp_bus.hdr_ready = 1'b1;
    udp_bus.tready    = 1'b1;
    wait_ready();
    cmd_bus.valid = 1'b1;
    step();
    cmd_bus.valid = 1'b0;
    tests++; if (udp_bus.hdr_valid !== 1'b1) begin fails++; $display("FAIL single_hdr_valid: got %b want 1", udp_bus.hdr_valid); end
    tests++; if (udp_bus.tvalid !== 1'b1) begin fails++; $display("FAIL single_tvalid: got %b want 1", udp_bus.tvalid); end
    tests++; if (cmd_bus.ready !== 1'b0) begin fails++; $display("FAIL single_ready_drop: got %b want 0", cmd_bus.ready); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %b want 1", busy); end
    tests++; if (udp_bus.length !== 16'd52) begin fails++; $display("FAIL single_udp_length: got %0d want 52", udp_bus.length); end
    tests++; if (udp_bus.tdata[31:8] !== 24'h110000) begin fails++; $display("FAIL single_rem_qpn_bytes: got %h want 110000", udp_bus.tdata[31:8]); end
    tests++; if (udp_bus.tdata[135:104] !== 32'hEFBEADDE) begin fails++; $display("FAIL single_r_key_bytes: got %h want efbeadde", udp_bus.tdata[135:104]); end
    tests++; if (udp_bus.tdata[202:200] !== 3'b011) begin fails++; $display("FAIL single_tx_flags: got %b want 011", udp_bus.tdata[202:200]); end
    tests++; if (udp_bus.tdata[199:136] !== 64'h8877_6655_4433_2211) begin fails++; $display("FAIL single_base_addr_bytes: got %h want 8877665544332211", udp_bus.tdata[199:136]); end
    tests++; if (udp_bus.tdata[351:336] !== 16'hB712) begin fails++; $display("FAIL single_udp_port_bytes: got %h want b712", udp_bus.tdata[351:336]); end
    tests++; if (udp_bus.tdata !== exp) begin fails++; $display("FAIL single_tdata: got %h want %h", udp_bus.tdata, exp); end
    tests++; if (udp_bus.tkeep !== 64'h0000_0FFF_FFFF_FFFF) begin fails++; $display("FAIL single_tkeep: got %h want 00000fffffffffff", udp_bus.tkeep); end
    tests++; if (udp_bus.tlast !== 1'b1 || udp_bus.tuser !== 1'b0) begin fails++; $display("FAIL single_tlast_tuser: got %b/%b want 1/0", udp_bus.tlast, udp_bus.tuser); end
    tests++; if (udp_bus.ip_source_ip !== 32'hC0A8_0001 || udp_bus.ip_dest_ip !== 32'hC0A8_0002) begin fails++; $display("FAIL single_ips: got %h/%h want c0a80001/c0a80002", udp_bus.ip_source_ip, udp_bus.ip_dest_ip); end
    tests++; if (udp_bus.source_port !== 16'hC0DE || udp_bus.dest_port !== 16'h4321) begin fails++; $display("FAIL single_ports: got %h/%h want c0de/4321", udp_bus.source_port, udp_bus.dest_port); end
    tests++; if (udp_bus.ip_ttl !== 8'd64 || udp_bus.ip_dscp !== 6'd0 || udp_bus.ip_ecn !== 2'd0 || udp_bus.checksum !== 16'd0) begin fails++; $display("FAIL single_hdr_consts: ttl=%0d dscp=%0d ecn=%0d csum=%h want 64/0/0/0", udp_bus.ip_ttl, udp_bus.ip_dscp, udp_bus.ip_ecn, udp_bus.checksum); end
    tests++; if (frame_count !== fc_exp) begin fails++; $display("FAIL single_fc_mid: got %0d want %0d", frame_count, fc_exp); end
    step();
    fc_exp = fc_exp + 32'd1;
    tests++; if (udp_bus.hdr_valid !== 1'b0 || udp_bus.tvalid !== 1'b0) begin fails++; $display("FAIL single_valids_clear: got %b/%b want 0/0", udp_bus.hdr_valid, udp_bus.tvalid); end
    tests++; if (frame_count !== fc_exp) begin fails++; $display("FAIL single_frame_count: got %0d want %0d", frame_count, fc_exp); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_clear: got %b want 0", busy); end
    tests++; if (cmd_bus.ready !== RDY_AFTER) begin fails++; $display("FAIL single_ready_return: got %b want %b", cmd_bus.ready, RDY_AFTER); end
  endtask

  task automatic test_flags_packed();
    logic [511:0] exp;
    set_cmd(5);
    cmd_bus.qp_valid      = 1'b0;
    cmd_bus.tx_valid      = 1'b0;
    cmd_bus.tx_start      = 1'b0;
    cmd_bus.tx_write_type = 1'b1;
    cmd_bus.rem_qpn       = 24'hA1B2C3;
    exp = model_payload();
    wait_ready();
    cmd_bus.valid = 1'b1;
    step();
    cmd_bus.valid = 1'b0;
    tests++; if (udp_bus.tdata[7:0] !== 8'h00) begin fails++; $display("FAIL flags_byte0: got %h want 00", udp_bus.tdata[7:0]); end
    tests++; if (udp_bus.tdata[207:200] !== 8'h04) begin fails++; $display("FAIL flags_byte25: got %h want 04", udp_bus.tdata[207:200]); end
    tests++; if (udp_bus.tdata[31:8] !== 24'hC3B2A1) begin fails++; $display("FAIL flags_rem_qpn: got %h want c3b2a1", udp_bus.tdata[31:8]); end
    tests++; if (udp_bus.tdata !== exp) begin fails++; $display("FAIL flags_tdata: got %h want %h", udp_bus.tdata, exp); end
    step();
    fc_exp = fc_exp + 32'd1;
    tests++; if (frame_count !== fc_exp) begin fails++; $display("FAIL flags_frame_count: got %0d want %0d", frame_count, fc_exp); end
  endtask

  task automatic test_hdr_stall();
    logic [31:0] sip, dip;
    set_cmd(7);
    sip = cmd_bus.ip_source_ip;
    dip = cmd_bus.ip_dest_ip;
    udp_bus.hdr_ready = 1'b0;
    udp_bus.tready    = 1'b1;
    wait_ready();
    cmd_bus.valid = 1'b1;
    step();
    set_cmd(99);
    for (int i = 0; i < 5; i++) begin
      tests++; if (udp_bus.hdr_valid !== 1'b1) begin fails++; $display("FAIL hdr_stall_valid[%0d]: got %b want 1", i, udp_bus.hdr_valid); end
      tests++; if (udp_bus.ip_source_ip !== sip || udp_bus.ip_dest_ip !== dip) begin fails++; $display("FAIL hdr_stall_data[%0d]: got %h/%h want %h/%h", i, udp_bus.ip_source_ip, udp_bus.ip_dest_ip, sip, dip); end
      tests++; if (udp_bus.tvalid !== (i == 0)) begin fails++; $display("FAIL hdr_stall_tvalid[%0d]: got %b want %b", i, udp_bus.tvalid, (i == 0)); end
      tests++; if (busy !== 1'b1 || cmd_bus.ready !== 1'b0) begin fails++; $display("FAIL hdr_stall_busy[%0d]: busy=%b ready=%b want 1/0", i, busy, cmd_bus.ready); end
      tests++; if (frame_count !== fc_exp) begin fails++; $display("FAIL hdr_stall_fc[%0d]: got %0d want %0d", i, frame_count, fc_exp); end
      step();
    end
    tests++; if (udp_bus.hdr_valid !== 1'b1) begin fails++; $display("FAIL hdr_stall_hold: got %b want 1", udp_bus.hdr_valid); end
    udp_bus.hdr_ready = 1'b1;
    step();
    cmd_bus.valid = 1'b0;
    fc_exp = fc_exp + 32'd1;
    tests++; if (udp_bus.hdr_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL hdr_stall_done: hdr_valid=%b busy=%b want 0/0", udp_bus.hdr_valid, busy); end
    tests++; if (frame_count !== fc_exp) begin fails++; $display("FAIL hdr_stall_frame_count: got %0d want %0d", frame_count, fc_exp); end
    tests++; if (cmd_bus.ready !== RDY_AFTER) begin fails++; $display("FAIL hdr_stall_ready: got %b want %b", cmd_bus.ready, RDY_AFTER); end
  endtask

  task automatic test_payload_stall();
    logic [511:0] exp;
    set_cmd(10);
    exp = model_payload();
    udp_bus.hdr_ready = 1'b1;
    udp_bus.tready    = 1'b0;
    wait_ready();
    cmd_bus.valid = 1'b1;
    step();
    cmd_bus.valid = 1'b0;
    set_cmd(42);
    for (int i = 0; i < 3; i++) begin
      tests++; if (udp_bus.tvalid !== 1'b1 || udp_bus.tdata !== exp) begin fails++; $display("FAIL pay_stall_hold[%0d]: tvalid=%b tdata=%h want 1/%h", i, udp_bus.tvalid, udp_bus.tdata, exp); end
      tests++; if (udp_bus.hdr_valid !== (i == 0)) begin fails++; $display("FAIL pay_stall_hdr_valid[%0d]: got %b want %b", i, udp_bus.hdr_valid, (i == 0)); end
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL pay_stall_busy[%0d]: got %b want 1", i, busy); end
      step();
    end
    tests++; if (udp_bus.tvalid !== 1'b1) begin fails++; $display("FAIL pay_stall_still: got %b want 1", udp_bus.tvalid); end
    udp_bus.tready = 1'b1;
    step();
    fc_exp = fc_exp + 32'd1;
    tests++; if (udp_bus.tvalid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL pay_stall_done: tvalid=%b busy=%b want 0/0", udp_bus.tvalid, busy); end
    tests++; if (frame_count !== fc_exp) begin fails++; $display("FAIL pay_stall_frame_count: got %0d want %0d", frame_count, fc_exp); end
    step();
    tests++; if (frame_count !== fc_exp) begin fails++; $display("FAIL pay_stall_count_once: got %0d want %0d", frame_count, fc_exp); end
  endtask

  task automatic test_back_to_back();
    logic [511:0] exp;
    logic [31:0]  fc_start;
    int cyc = 0;
    int accepts = 0;
    int last = -1;
    udp_bus.hdr_ready = 1'b1;
    udp_bus.tready    = 1'b1;
    wait_ready();
    fc_start = frame_count;
    set_cmd(20);
    cmd_bus.valid = 1'b1;
    while (accepts < 10 && cyc < 400) begin
      if (cmd_bus.ready === 1'b1) begin
        if (last >= 0) begin
          tests++; if (cyc - last != SPACING) begin fails++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", accepts, cyc - last, SPACING); end
        end
        last = cyc;
        accepts++;
        exp = model_payload();
        step();
        cyc++;
        tests++; if (udp_bus.tvalid !== 1'b1 || udp_bus.tdata !== exp) begin fails++; $display("FAIL b2b_payload[%0d]: tvalid=%b tdata=%h want 1/%h", accepts, udp_bus.tvalid, udp_bus.tdata, exp); end
        tests++; if (udp_bus.tdata[511:352] !== 160'd0) begin fails++; $display("FAIL b2b_pad_zero[%0d]: got %h want 0", accepts, udp_bus.tdata[511:352]); end
        set_cmd(20 + accepts);
      end else begin
        step();
        cyc++;
      end
    end
    cmd_bus.valid = 1'b0;
    tests++; if (accepts != 10) begin fails++; $display("FAIL b2b_accepts: got %0d want 10", accepts); end
    step();
    fc_exp = fc_start + 32'd10;
    tests++; if (frame_count !== fc_exp) begin fails++; $display("FAIL b2b_frame_count: got %0d want %0d", frame_count, fc_exp); end
  endtask

  task automatic test_reset_mid_frame();
    set_cmd(3);
    udp_bus.hdr_ready = 1'b0;
    udp_bus.tready    = 1'b1;
    wait_ready();
    cmd_bus.valid = 1'b1;
    step();
    cmd_bus.valid = 1'b0;
    step();
    tests++; if (udp_bus.hdr_valid !== 1'b1) begin fails++; $display("FAIL rstmid_pending: got %b want 1", udp_bus.hdr_valid); end
    rst = 1'b1;
    step();
    fc_exp = 32'd0;
    tests++; if (udp_bus.hdr_valid !== 1'b0 || udp_bus.tvalid !== 1'b0) begin fails++; $display("FAIL rstmid_valids: got %b/%b want 0/0", udp_bus.hdr_valid, udp_bus.tvalid); end
    tests++; if (frame_count !== fc_exp) begin fails++; $display("FAIL rstmid_frame_count: got %0d want 0", frame_count); end
    tests++; if (cmd_bus.ready !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rstmid_ready_busy: ready=%b busy=%b want 0/0", cmd_bus.ready, busy); end
    rst = 1'b0;
    udp_bus.hdr_ready = 1'b1;
    step();
    tests++; if (cmd_bus.ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready_return: got %b want 1", cmd_bus.ready); end
    tests++; if (udp_bus.hdr_valid !== 1'b0 || frame_count !== 32'd0) begin fails++; $display("FAIL rstmid_discarded: hdr_valid=%b fc=%0d want 0/0", udp_bus.hdr_valid, frame_count); end
  endtask

  initial begin
    rst = 1'b1;
    cmd_bus.valid     = 1'b0;
    udp_bus.hdr_ready = 1'b0;
    udp_bus.tready    = 1'b0;
    set_cmd(0);
    test_reset();
    test_single_frame();
    test_flags_packed();
    test_hdr_stall();
    test_payload_stall();
    test_back_to_back();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
